// File: rtl/mtr_drv_pwm.sv
// mtr_drv_pwm: signed speed to dead-time-protected complementary PWM pairs for two H-bridges.
// Define OVR_I_SHTDWN_EN to build the sticky over-current shutdown logic.
module mtr_drv_pwm #(
    parameter int DEADTIME    = 66,
    parameter int OVR_I_BLANK = 128,
    parameter int OVR_I_LIMIT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    input  logic        OVR_I_lft,
    input  logic        OVR_I_rght,
    output logic        PWM1_lft,
    output logic        PWM2_lft,
    output logic        PWM1_rght,
    output logic        PWM2_rght,
    output logic        pwm_synch,
    output logic        OVR_I_shtdwn
);
    localparam logic [6:0] DT = 7'(DEADTIME);
    logic [10:0] cnt, duty_lft, duty_rght;
    logic        raw_lft, raw_rght, raw_lft_nxt, raw_rght_nxt, kill;
    logic [6:0]  dcnt_lft, dcnt_rght;
    assign raw_lft_nxt  = cnt < duty_lft;
    assign raw_rght_nxt = cnt < duty_rght;
    // dead counters restart on the same edge raw changes, so PWM1/2 lag raw by DEADTIME+1
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pwm_synch <= 1'b0;
            duty_lft  <= 11'h400;
            duty_rght <= 11'h400;
            raw_lft   <= 1'b0;
            raw_rght  <= 1'b0;
            dcnt_lft  <= '0;
            dcnt_rght <= '0;
            PWM1_lft  <= 1'b0;
            PWM2_lft  <= 1'b0;
            PWM1_rght <= 1'b0;
            PWM2_rght <= 1'b0;
        end else begin
            cnt       <= cnt + 11'd1;
            pwm_synch <= cnt == '0;
            if (cnt == '0) begin
                duty_lft  <= 11'h400 + lft_spd[11:1];
                duty_rght <= 11'h400 + rght_spd[11:1];
            end
            raw_lft   <= raw_lft_nxt;
            raw_rght  <= raw_rght_nxt;
            dcnt_lft  <= (raw_lft_nxt != raw_lft) ? 7'd0 : dcnt_lft + 7'(dcnt_lft != DT);
            dcnt_rght <= (raw_rght_nxt != raw_rght) ? 7'd0 : dcnt_rght + 7'(dcnt_rght != DT);
            PWM1_lft  <= ~kill & raw_lft & (dcnt_lft == DT);
            PWM2_lft  <= ~kill & ~raw_lft & (dcnt_lft == DT);
            PWM1_rght <= ~kill & raw_rght & (dcnt_rght == DT);
            PWM2_rght <= ~kill & ~raw_rght & (dcnt_rght == DT);
        end
    end
`ifdef OVR_I_SHTDWN_EN
    logic       flag;
    logic [3:0] fcnt;
    assign kill = OVR_I_shtdwn;
    always_ff @(posedge clk) begin
        if (rst) begin
            flag         <= 1'b0;
            fcnt         <= '0;
            OVR_I_shtdwn <= 1'b0;
        end else begin
            flag         <= (cnt == '0) ? 1'b0 : flag | ((cnt >= 11'(OVR_I_BLANK)) &
                            ((OVR_I_lft & PWM1_lft) | (OVR_I_rght & PWM1_rght)));
            if (cnt == '0)
                fcnt <= flag ? fcnt + 4'(fcnt != 4'hF) : 4'd0;
            OVR_I_shtdwn <= OVR_I_shtdwn | (fcnt == 4'(OVR_I_LIMIT));
        end
    end
`else
    logic unused_ovr;
    assign unused_ovr   = OVR_I_lft ^ OVR_I_rght;
    assign kill         = 1'b0;
    assign OVR_I_shtdwn = 1'b0;
`endif
endmodule
